// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through FIFO that buffers host words for uart_tx.
// Define UART_TX_FIFO_FLUSH_EN to add a synchronous active-high flush input.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  push, pop, flush_req;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Status comes only from registered occupancy, so ready never sees m_axis_tready.
    assign full          = (level_q == LEVEL_FULL);
    assign empty         = (level_q == '0);
    assign level         = level_q;
    assign s_axis_tready = ~full;
    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = mem_q[rd_ptr_q];

    assign push = s_axis_tvalid & s_axis_tready;
    assign pop  = m_axis_tvalid & m_axis_tready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      level_d = level_q + LEVEL_ONE;
            else if (pop && !push) level_d = level_q - LEVEL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush_req) mem_q[wr_ptr_q] <= s_axis_tdata;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the width of a data word, matching the uart_tx data width.
REQ-002 Parameter DEPTH_LOG2, default 4, gives a storage depth of DEPTH = 2**DEPTH_LOG2 words; legal range is 1 to 8.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port s_axis_tdata, input, DATA_WIDTH bits: the write word from the host.
REQ-006 Port s_axis_tvalid, input, 1 bit: the host offers a word.
REQ-007 Port s_axis_tready, output, 1 bit: the FIFO can accept a word.
REQ-008 Port m_axis_tdata, output, DATA_WIDTH bits: the head word, which feeds uart_tx s_axis_tdata.
REQ-009 Port m_axis_tvalid, output, 1 bit: a head word is present.
REQ-010 Port m_axis_tready, input, 1 bit: the consumer (uart_tx) accepts the head word.
REQ-011 Port level, output, DEPTH_LOG2+1 bits: the number of words stored, 0..DEPTH.
REQ-012 Port full, output, 1 bit: high when level == DEPTH.
REQ-013 Port empty, output, 1 bit: high when level == 0.

Function
REQ-014 The FIFO SHALL store words in a DEPTH-entry register array, using a write pointer, a read pointer and an occupancy counter.
REQ-015 Pointers SHALL be DEPTH_LOG2 bits wide and wrap from DEPTH-1 to 0 without any special case.
REQ-016 A push SHALL occur on a clock edge with s_axis_tvalid && s_axis_tready; it writes mem[wr_ptr] and increments wr_ptr.
REQ-017 A pop SHALL occur on a clock edge with m_axis_tvalid && m_axis_tready; it increments rd_ptr.
REQ-018 s_axis_tready SHALL equal !full and SHALL not depend combinationally on m_axis_tready, so there is no pass-through when full.
REQ-019 m_axis_tvalid SHALL equal !empty.
REQ-020 m_axis_tdata SHALL equal mem[rd_ptr] (first-word-fall-through); its value is don't-care while empty.
REQ-021 Latency: a word pushed at edge N SHALL be presented with m_axis_tvalid high from edge N onward when the FIFO was empty, i.e. one cycle push-to-valid.
REQ-022 Simultaneous push and pop SHALL leave level unchanged and move both pointers.
REQ-023 Full plus s_axis_tvalid SHALL write nothing, leave the pointers unchanged and hold s_axis_tready low.
REQ-024 Empty plus m_axis_tready SHALL pop nothing and leave rd_ptr unchanged.
REQ-025 level, full and empty SHALL be registered or derived only from registered state, never from handshake inputs.
REQ-026 m_axis_tdata SHALL remain stable while m_axis_tvalid is high and m_axis_tready is low, and word order SHALL be strictly preserved.

Reset
REQ-027 Assertion of rst_n low SHALL immediately, without a clock, clear wr_ptr, rd_ptr and level to 0.
REQ-028 The resulting output values during reset SHALL be: s_axis_tready=1, m_axis_tvalid=0, empty=1, full=0, level=0.
REQ-029 Memory contents SHALL not be reset.
REQ-030 Reset mid-transfer SHALL discard all stored words, and no pop SHALL be signalled during or after reset.
REQ-031 Deassertion of rst_n SHALL be synchronised externally, and the first push SHALL be accepted on the first edge after deassertion.

Configuration
REQ-032 Macro UART_TX_FIFO_FLUSH_EN, when defined, SHALL add an input port flush (1 bit, synchronous, active-high).
REQ-033 With the macro defined, flush high at an edge SHALL set the pointers and level to 0, overriding any push or pop on the same edge.
REQ-034 Without the macro, the flush port and its logic SHALL be absent, and behaviour SHALL be exactly REQ-014 to REQ-026.

Verification (bench uses DATA_WIDTH=8, DEPTH_LOG2=2, DEPTH=4)
REQ-035 Single word: after reset, push 0xA5 with m_axis_tready=0 -> next cycle m_axis_tvalid=1, m_axis_tdata=0xA5, level=1, empty=0.
REQ-036 Fill and overflow attempt: push 0x01,0x02,0x03,0x04,0x05 back-to-back with m_axis_tready=0 -> full=1 and s_axis_tready=0 after the 4th push, 0x05 not accepted, level=4; then drain -> output order 0x01..0x04 and empty=1.
REQ-037 Concurrent traffic: at level=2, hold tvalid=1 and tready=1 on both sides for 10 cycles -> level stays 2, pointers wrap at least twice, no word lost or reordered.
REQ-038 Backpressure: m_axis_tready toggled 0/1 each cycle while pushing 0x10..0x17 -> output sequence 0x10..0x17 with data stable while stalled.
REQ-039 Async reset: assert rst_n=0 mid-cycle at level=3 -> outputs go to REQ-028 values before the next edge; after release, m_axis_tvalid=0 until a new push.
REQ-040 Flush (UART_TX_FIFO_FLUSH_EN defined): at level=3, flush=1 with a simultaneous push of 0x55 -> level=0, empty=1, and 0x55 discarded.
